// File: rtl/s2_result_collector_if.sv
// s2_result_collector_if: capture input and show-ahead FIFO output bundle.
interface s2_result_collector_if #(
    parameter int DEPTH = 4
);
    logic                       slow_clk;
    logic [7:0]                 s2_result;
    logic                       out_ready;
    logic                       out_valid;
    logic [7:0]                 out_data;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic                       overflow;
    logic [15:0]                checksum;

    modport master (
        output slow_clk, s2_result, out_ready,
        input  out_valid, out_data, fifo_count, overflow, checksum
    );
    modport slave (
        input  slow_clk, s2_result, out_ready,
        output out_valid, out_data, fifo_count, overflow, checksum
    );
endinterface

// File: rtl/s2_result_collector.sv
// s2_result_collector: edge-detects slow_clk, drops SKIP fill captures, buffers results in a FIFO.
// Optional running checksum of pushed results under macro COLLECTOR_CHECKSUM_EN.
module s2_result_collector #(
    parameter int DEPTH = 4,
    parameter int SKIP  = 2
) (
    input logic                 fast_clk,
    input logic                 rst_n,
    s2_result_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [0:0] RST_STATE = (SKIP == 0) ? RUN : FILL;
    localparam logic [3:0] SKIP_N = 4'(SKIP);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic          slow_q, slow_d;
    logic [0:0]    state_q, state_d;
    logic [3:0]    skip_q, skip_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic          cap, full, push, pop;

    always_comb begin
        cap        = bus.slow_clk & ~slow_q;
        full       = count_q == FULL_CNT;
        pop        = (count_q != '0) & bus.out_ready;
        push       = cap & (state_q == RUN) & (~full | pop);
        slow_d     = bus.slow_clk;
        skip_d     = skip_q;
        state_d    = state_q;
        if (cap && state_q == FILL) begin
            skip_d  = skip_q + 4'd1;
            state_d = (skip_q + 4'd1 == SKIP_N) ? RUN : FILL;
        end
        wr_d       = push ? wr_q + 1'b1 : wr_q;
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d = overflow_q | (cap & (state_q == RUN) & full & ~pop);
        mem_d      = mem_q;
        if (push) mem_d[wr_q] = bus.s2_result;
    end

    // slow_q follows slow_clk even in reset so a level held across release is not an edge
    always_ff @(posedge fast_clk) begin
        slow_q <= slow_d;
        if (!rst_n) begin
            state_q    <= RST_STATE;
            skip_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.out_valid  = count_q != '0;
    assign bus.out_data   = mem_q[rd_q];
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;

`ifdef COLLECTOR_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    always_comb checksum_d = checksum_q + (push ? {8'd0, bus.s2_result} : 16'd0);

    always_ff @(posedge fast_clk) begin
        if (!rst_n) checksum_q <= '0;
        else        checksum_q <= checksum_d;
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_s2_result_collector.sv
// tb_s2_result_collector: directed tests for s2_result_collector (DEPTH=4, SKIP=2).
module tb_s2_result_collector;
    logic fast_clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_fail = 0;

    s2_result_collector_if #(.DEPTH(4)) bus ();

    s2_result_collector #(.DEPTH(4), .SKIP(2)) dut (
        .fast_clk (fast_clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
    );

    always #5 fast_clk = ~fast_clk;

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        bus.slow_clk = 1'b0;
        bus.s2_result = 8'd0;
        bus.out_ready = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic rise(input logic [7:0] v);
        bus.s2_result = v;
        bus.slow_clk = 1'b1;
        tick();
    endtask

    task automatic fall();
        bus.slow_clk = 1'b0;
        tick();
    endtask

    task automatic capture(input logic [7:0] v);
        rise(v);
        fall();
    endtask

    task automatic test_reset();
        do_reset(4);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0d want 0", bus.out_valid); end
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0d want 0", bus.overflow); end
        n_cmp++; if (bus.checksum !== 16'd0) begin n_fail++; $display("FAIL reset_checksum got %0d want 0", bus.checksum); end
    endtask

    task automatic test_stream();
        logic [7:0] vals [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        do_reset(4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rise(vals[i]);
            n_cmp++; if (bus.out_valid !== (i >= 2)) begin n_fail++; $display("FAIL stream_valid_rise[%0d] got %0d want %0d", i, bus.out_valid, i >= 2); end
            n_cmp++; if (bus.fifo_count > 3'd1) begin n_fail++; $display("FAIL stream_count[%0d] got %0d want <=1", i, bus.fifo_count); end
            if (i >= 2) begin
                n_cmp++; if (bus.out_data !== vals[i]) begin n_fail++; $display("FAIL stream_data[%0d] got %0d want %0d", i, bus.out_data, vals[i]); end
            end
            fall();
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_fall[%0d] got %0d want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_overflow();
        do_reset(2);
        capture(8'd0);
        capture(8'd0);
        for (int i = 1; i <= 6; i++) begin
            capture(8'(i));
            n_cmp++; if (bus.out_data !== 8'd1) begin n_fail++; $display("FAIL ovf_hold_data[%0d] got %0d want 1", i, bus.out_data); end
            n_cmp++; if (bus.overflow !== (i >= 5)) begin n_fail++; $display("FAIL ovf_flag[%0d] got %0d want %0d", i, bus.overflow, i >= 5); end
        end
        n_cmp++; if (bus.fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", bus.fifo_count); end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (bus.out_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_drain[%0d] got %0d want %0d", i, bus.out_data, i); end
            tick();
        end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty_valid got %0d want 0", bus.out_valid); end
        tick();
        tick();
        bus.out_ready = 1'b0;
        capture(8'd9);
        n_cmp++; if (bus.fifo_count !== 3'd1) begin n_fail++; $display("FAIL empty_pop_count got %0d want 1", bus.fifo_count); end
        n_cmp++; if (bus.out_data !== 8'd9) begin n_fail++; $display("FAIL empty_pop_data got %0d want 9", bus.out_data); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0d want 1", bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset(2);
        capture(8'd0);
        capture(8'd0);
        for (int i = 1; i <= 4; i++) capture(8'(i));
        bus.s2_result = 8'd5;
        bus.slow_clk = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_pp_count got %0d want 4", bus.fifo_count); end
        n_cmp++; if (bus.out_data !== 8'd2) begin n_fail++; $display("FAIL full_pp_head got %0d want 2", bus.out_data); end
        fall();
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_overflow got %0d want 0", bus.overflow); end
        bus.out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            n_cmp++; if (bus.out_data !== 8'(i)) begin n_fail++; $display("FAIL full_pp_drain[%0d] got %0d want %0d", i, bus.out_data, i); end
            tick();
        end
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL full_pp_final got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_mid_reset();
        do_reset(2);
        capture(8'd0);
        capture(8'd0);
        for (int i = 1; i <= 3; i++) capture(8'(i));
        n_cmp++; if (bus.fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d want 3", bus.fifo_count); end
        do_reset(1);
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", bus.fifo_count); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %0d want 0", bus.out_valid); end
        capture(8'd7);
        capture(8'd8);
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_skip_count got %0d want 0", bus.fifo_count); end
        capture(8'd9);
        n_cmp++; if (bus.out_data !== 8'd9) begin n_fail++; $display("FAIL mid_first_data got %0d want 9", bus.out_data); end
    endtask

    task automatic test_checksum();
        logic [15:0] exp_sum;
        do_reset(2);
        capture(8'd11);
        capture(8'd22);
        capture(8'd200);
        capture(8'd100);
        capture(8'd50);
`ifdef COLLECTOR_CHECKSUM_EN
        exp_sum = 16'd350;
`else
        exp_sum = 16'd0;
`endif
        n_cmp++; if (bus.checksum !== exp_sum) begin n_fail++; $display("FAIL checksum_3 got %0d want %0d", bus.checksum, exp_sum); end
        capture(8'd25);
        capture(8'd99);
`ifdef COLLECTOR_CHECKSUM_EN
        exp_sum = 16'd375;
`endif
        n_cmp++; if (bus.checksum !== exp_sum) begin n_fail++; $display("FAIL checksum_drop got %0d want %0d", bus.checksum, exp_sum); end
    endtask

    task automatic test_slow_high_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        bus.slow_clk = 1'b1;
        bus.s2_result = 8'd33;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        fall();
        capture(8'd1);
        capture(8'd2);
        n_cmp++; if (bus.fifo_count !== 3'd0) begin n_fail++; $display("FAIL slowhi_skip_count got %0d want 0", bus.fifo_count); end
        capture(8'h55);
        n_cmp++; if (bus.fifo_count !== 3'd1) begin n_fail++; $display("FAIL slowhi_count got %0d want 1", bus.fifo_count); end
        n_cmp++; if (bus.out_data !== 8'h55) begin n_fail++; $display("FAIL slowhi_data got %0h want 55", bus.out_data); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_checksum();
        test_slow_high_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/s2_result_collector.md
S2_RESULT_COLLECTOR -- requirements
Module: s2_result_collector

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, min 2.
REQ-002 Parameter SKIP, default 2, pipeline-fill captures discarded after reset; range 0..15.
REQ-003 fast_clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low, sampled on fast_clk.
REQ-005 slow_clk  input  1  divided clock from the pipeline; sampled as data, never used as a clock.
REQ-006 s2_result  input  8  stage-2 result, updated once per slow_clk period.
REQ-007 out_ready  input  1  downstream ready to accept.
REQ-008 out_valid  output  1  head entry available.
REQ-009 out_data  output  8  head entry value, show-ahead.
REQ-010 fifo_count  output  $clog2(DEPTH)+1  occupied entries.
REQ-011 overflow  output  1  sticky, a capture was dropped.
REQ-012 checksum  output  16  running sum of accepted captures (see Configuration).

Function
REQ-013 The block SHALL register slow_clk into slow_q each fast_clk edge; capture event = slow_clk & ~slow_q.
REQ-014 On a capture event the block SHALL sample s2_result as presented in that same fast_clk cycle.
REQ-015 The first SKIP capture events after reset SHALL be discarded via a 4-bit skip counter, which then saturates.
REQ-016 States: FILL (skip counter < SKIP) and RUN; FILL->RUN on the SKIP-th capture; no return to FILL except by reset; SKIP=0 enters RUN directly out of reset.
REQ-017 In RUN, each capture SHALL push into a circular FIFO with write/read pointers that wrap at DEPTH.
REQ-018 Pop SHALL occur on a fast_clk edge with out_valid & out_ready; out_data SHALL show the next entry in the following cycle.
REQ-019 out_valid SHALL equal (fifo_count != 0); out_data is don't-care when out_valid is 0.
REQ-020 Push and pop in the same cycle SHALL both take effect; fifo_count unchanged, including when full or when holding exactly one entry.
REQ-021 Push when full without a simultaneous pop SHALL drop the capture, leave FIFO contents unchanged, and set overflow the next cycle.
REQ-022 Pop-less out_ready when empty SHALL have no effect; pointers never underflow.
REQ-023 Capture-to-out_valid latency SHALL be 1 fast_clk cycle when the FIFO was empty.
REQ-024 out_data and out_valid SHALL be held stable while out_valid & ~out_ready.

Reset
REQ-025 When rst_n=0 at a fast_clk edge: out_valid=0, fifo_count=0, overflow=0, checksum=0, pointers=0, skip counter=0, slow_q=0, state FILL.
REQ-026 Reset mid-operation SHALL discard all buffered entries; no pop or push completes on the reset edge.
REQ-027 A slow_clk already high when reset releases SHALL NOT produce a capture event (slow_q reset to 0 is overridden by loading slow_clk during reset).

Configuration
REQ-028 Macro COLLECTOR_CHECKSUM_EN defined: checksum SHALL add zero-extended s2_result on every FIFO push (not drops, not skips), mod 2^16, visible the cycle after the push.
REQ-029 Macro undefined: checksum SHALL be constant 0 and no adder SHALL be synthesized.

Verification
REQ-030 Reset held 4 cycles, slow_clk toggles, s2_result 10,20,30,40 per period, SKIP=2, out_ready=1 -> outputs 30 then 40, out_valid 1-cycle pulses, fifo_count never above 1.
REQ-031 out_ready=0, DEPTH=4, six RUN captures 1..6 -> fifo_count=4, overflow=1, then drain yields 1,2,3,4.
REQ-032 FIFO full, out_ready=1 in the capture cycle -> pop 1 and push 5 both complete, fifo_count stays 4, overflow stays 0.
REQ-033 Three entries buffered, rst_n=0 for 1 cycle -> fifo_count=0, out_valid=0, next two captures skipped.
REQ-034 COLLECTOR_CHECKSUM_EN defined, captures 200,100,50 pushed -> checksum=350; undefined -> checksum=0 throughout.
REQ-035 slow_clk high during reset release -> no capture until its next rising edge.
